// File: rtl/shift_cipher_pkg.sv
// ============================================================================
// Module  : shift_cipher_pkg
// Brief   : Shared types, constants and the alphabetic helper for the shift
//           cipher decryptor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_cipher_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic MODE_CAESAR   = 1'b0;
  localparam logic MODE_VIGENERE = 1'b1;
  localparam int   DRAIN_CYCLES  = 2;

  localparam logic [7:0] ASCII_UPPER_A = 8'h41;
  localparam logic [7:0] ASCII_UPPER_Z = 8'h5A;
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;
  localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;
  localparam int         ALPHA_SIZE    = 26;

  // kmod must already be reduced below ALPHA_SIZE, so one conditional subtract suffices.
  function automatic logic [7:0] alpha_dec(input logic [7:0] sym,
                                           input logic [7:0] base,
                                           input logic [7:0] kmod);
    logic [7:0] off;
    off = sym - base + 8'(ALPHA_SIZE) - kmod;
    if (off >= 8'(ALPHA_SIZE)) off = off - 8'(ALPHA_SIZE);
    return off + base;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_cipher_sub.sv
// ============================================================================
// Module  : shift_cipher_sub
// Brief   : Combinational symbol decrypt; SHIFT_CIPHER_ALPHA_EN selects the
//           mod-26 letter variant instead of plain mod 2^D_WIDTH subtraction.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_cipher_sub
  import shift_cipher_pkg::*;
#(
  parameter int D_WIDTH = 8
) (
  input  logic [D_WIDTH-1:0] i_sym,
  input  logic [D_WIDTH-1:0] i_key,
  output logic [D_WIDTH-1:0] o_plain
);

`ifdef SHIFT_CIPHER_ALPHA_EN
  logic [D_WIDTH-1:0] w_kmod;
  logic               w_upper;
  logic               w_lower;

  assign w_kmod  = i_key % D_WIDTH'(ALPHA_SIZE);
  assign w_upper = (i_sym >= D_WIDTH'(ASCII_UPPER_A)) && (i_sym <= D_WIDTH'(ASCII_UPPER_Z));
  assign w_lower = (i_sym >= D_WIDTH'(ASCII_LOWER_A)) && (i_sym <= D_WIDTH'(ASCII_LOWER_Z));

  always_comb begin
    o_plain = i_sym;
    if (w_upper)
      o_plain = D_WIDTH'(alpha_dec(i_sym[7:0], ASCII_UPPER_A, w_kmod[7:0]));
    else if (w_lower)
      o_plain = D_WIDTH'(alpha_dec(i_sym[7:0], ASCII_LOWER_A, w_kmod[7:0]));
  end
`else
  assign o_plain = i_sym - i_key;
`endif

endmodule

`default_nettype wire

// File: rtl/shift_cipher_decryption.sv
// ============================================================================
// Module  : shift_cipher_decryption
// Brief   : Two-stage Caesar/Vigenere stream decryptor with valid/busy
//           handshake; SHIFT_CIPHER_ALPHA_EN enables letter-only decryption.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_cipher_decryption
  import shift_cipher_pkg::*;
#(
  parameter int D_WIDTH = 8,
  parameter int KEY_LEN = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [D_WIDTH-1:0]         data_i,
  input  logic                       valid_i,
  input  logic                       last_i,
  input  logic                       mode_i,
  input  logic [KEY_LEN*D_WIDTH-1:0] key,
  output logic                       busy,
  output logic [D_WIDTH-1:0]         data_o,
  output logic                       valid_o
);

  localparam int IDX_W = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

  state_e                     r_state;
  logic                       r_mode;
  logic [KEY_LEN*D_WIDTH-1:0] r_key;
  logic [IDX_W-1:0]           r_idx;
  logic [1:0]                 r_drain_cnt;
  logic                       r_busy;

  logic                       r_s1_valid;
  logic [D_WIDTH-1:0]         r_s1_sym;
  logic [D_WIDTH-1:0]         r_s1_key;
  logic [D_WIDTH-1:0]         r_data_o;
  logic                       r_valid_o;

  logic                       w_idle;
  logic                       w_accept;
  logic                       w_mode;
  logic [KEY_LEN*D_WIDTH-1:0] w_key_src;
  logic [D_WIDTH-1:0]         w_elems [KEY_LEN];
  logic [IDX_W-1:0]           w_sel_idx;
  logic [IDX_W-1:0]           w_idx_next;
  logic [D_WIDTH-1:0]         w_plain;

  // The opening symbol must see the key/mode on the pins, not the stale latch.
  assign w_idle    = (r_state == IDLE);
  assign w_accept  = valid_i && (r_state != DRAIN);
  assign w_mode    = w_idle ? mode_i : r_mode;
  assign w_key_src = w_idle ? key : r_key;

  for (genvar k = 0; k < KEY_LEN; k++) begin : g_key_elems
    assign w_elems[k] = w_key_src[k*D_WIDTH +: D_WIDTH];
  end

  always_comb begin
    w_sel_idx = '0;
    if (w_mode == MODE_VIGENERE) w_sel_idx = r_idx;
  end

  assign w_idx_next = (r_idx == IDX_W'(KEY_LEN - 1)) ? '0 : r_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mode      <= MODE_CAESAR;
      r_key       <= '0;
      r_idx       <= '0;
      r_drain_cnt <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (valid_i) begin
            r_mode <= mode_i;
            r_key  <= key;
            if (last_i) begin
              r_state     <= DRAIN;
              r_busy      <= 1'b1;
              r_drain_cnt <= '0;
            end else begin
              r_state <= RUN;
              r_idx   <= w_idx_next;
            end
          end
        end
        RUN: begin
          if (valid_i) begin
            if (last_i) begin
              r_state     <= DRAIN;
              r_busy      <= 1'b1;
              r_drain_cnt <= '0;
              r_idx       <= '0;
            end else begin
              r_idx <= w_idx_next;
            end
          end
        end
        DRAIN: begin
          if (r_drain_cnt == 2'(DRAIN_CYCLES - 1)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_drain_cnt <= r_drain_cnt + 2'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_idx   <= '0;
        end
      endcase
    end
  end

  shift_cipher_sub #(
    .D_WIDTH (D_WIDTH)
  ) u_sub (
    .i_sym   (r_s1_sym),
    .i_key   (r_s1_key),
    .o_plain (w_plain)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sym   <= '0;
      r_s1_key   <= '0;
      r_data_o   <= '0;
      r_valid_o  <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_sym <= data_i;
        r_s1_key <= w_elems[w_sel_idx];
      end
      r_valid_o <= r_s1_valid;
      if (r_s1_valid) r_data_o <= w_plain;
    end
  end

  assign busy    = r_busy;
  assign data_o  = r_data_o;
  assign valid_o = r_valid_o;

endmodule

`default_nettype wire

// File: tb/tb_shift_cipher_decryption.sv
// ============================================================================
// Module  : tb_shift_cipher_decryption
// Brief   : Directed plus randomized bench against a message-level reference
//           model of the shift cipher decryptor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_cipher_decryption;

  localparam int D_WIDTH = 8;
  localparam int KEY_LEN = 4;

  logic                       clk;
  logic                       rst;
  logic [D_WIDTH-1:0]         data_i;
  logic                       valid_i;
  logic                       last_i;
  logic                       mode_i;
  logic [KEY_LEN*D_WIDTH-1:0] key;
  logic                       busy;
  logic [D_WIDTH-1:0]         data_o;
  logic                       valid_o;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_n = 0;

  // Reference model state: message-level view, outputs delayed by two edges.
  bit m_open;
  int m_drain;
  int m_count;
  bit m_mode;
  int m_key [KEY_LEN];
  bit m_p1_v;
  int m_p1_d;
  bit m_out_v;
  int m_out_d;

  shift_cipher_decryption #(
    .D_WIDTH (D_WIDTH),
    .KEY_LEN (KEY_LEN)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_i),
    .valid_i (valid_i),
    .last_i  (last_i),
    .mode_i  (mode_i),
    .key     (key),
    .busy    (busy),
    .data_o  (data_o),
    .valid_o (valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc_n);
    end
  endtask

  function automatic int ref_dec(input int sym, input int k);
`ifdef SHIFT_CIPHER_ALPHA_EN
    if (sym >= 65 && sym <= 90)  return ((((sym - 65) - (k % 26)) % 26) + 26) % 26 + 65;
    if (sym >= 97 && sym <= 122) return ((((sym - 97) - (k % 26)) % 26) + 26) % 26 + 97;
    return sym;
`else
    return (sym - k) & ((1 << D_WIDTH) - 1);
`endif
  endfunction

  task automatic model_step();
    bit acc;
    int elem;
    if (rst) begin
      m_open = 0; m_drain = 0; m_count = 0;
      m_p1_v = 0; m_p1_d = 0; m_out_v = 0; m_out_d = 0;
    end else begin
      m_out_v = m_p1_v;
      if (m_p1_v) m_out_d = m_p1_d;
      acc = valid_i && (m_drain == 0);
      if (m_drain > 0) m_drain--;
      m_p1_v = acc;
      if (acc) begin
        if (!m_open) begin
          m_open = 1;
          m_count = 0;
          m_mode = mode_i;
          for (int k = 0; k < KEY_LEN; k++) m_key[k] = int'(key[k*D_WIDTH +: D_WIDTH]);
        end
        elem = m_mode ? m_key[m_count % KEY_LEN] : m_key[0];
        m_p1_d = ref_dec(int'(data_i), elem);
        m_count++;
        if (last_i) begin
          m_open = 0;
          m_drain = 2;
          m_count = 0;
        end
      end
    end
  endtask

  task automatic cycle(input logic r, input logic v, input logic l, input logic m,
                       input logic [KEY_LEN*D_WIDTH-1:0] k, input logic [D_WIDTH-1:0] d);
    @(negedge clk);
    rst = r; valid_i = v; last_i = l; mode_i = m; key = k; data_i = d;
    @(posedge clk);
    model_step();
    #1;
    cyc_n++;
    check_eq("valid_o", 32'(valid_o), 32'(m_out_v));
    check_eq("busy", 32'(busy), 32'(m_drain > 0));
    check_eq("data_o", 32'(data_o), 32'(m_out_d));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, '0, '0);
  endtask

  initial begin
    rst = 1; valid_i = 0; last_i = 0; mode_i = 0; key = '0; data_i = '0;

    // Reset held with valid_i asserted.
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 1, 32'h04030201, 8'h55);

    // Caesar, key element 0 = 3, with a gap and ignored input during DRAIN.
    cycle(0, 1, 0, 0, 32'h09080703, 8'h04);
    cycle(0, 1, 0, 0, 32'h09080703, 8'h05);
    cycle(0, 0, 0, 0, 32'h09080703, 8'h00);
    cycle(0, 1, 1, 0, 32'h09080703, 8'h17);
    cycle(0, 1, 0, 0, 32'h09080703, 8'h20);
    cycle(0, 1, 0, 0, 32'h09080703, 8'h20);
    idle(3);

    // Vigenere, six back-to-back symbols, then a second message with a key change mid-way.
    for (int i = 0; i < 6; i++) cycle(0, 1, (i == 5), 1, 32'h04030201, 8'h10);
    idle(3);
    cycle(0, 1, 0, 1, 32'h04030201, 8'h10);
    cycle(0, 1, 0, 0, 32'hA0B0C0D0, 8'h10);
    cycle(0, 1, 1, 0, 32'h11223344, 8'h10);
    idle(3);

    // Subtraction wrap-around.
    cycle(0, 1, 1, 0, 32'h00000003, 8'h01);
    idle(3);

    // Reset mid-message, then the next message must restart at element 0.
    cycle(0, 1, 0, 1, 32'h04030201, 8'h10);
    cycle(0, 1, 0, 1, 32'h04030201, 8'h10);
    cycle(1, 0, 0, 0, '0, '0);
    idle(2);
    cycle(0, 1, 0, 1, 32'h04030201, 8'h10);
    cycle(0, 1, 1, 1, 32'h04030201, 8'h10);
    idle(3);

`ifdef SHIFT_CIPHER_ALPHA_EN
    cycle(0, 1, 1, 0, 32'h00000003, 8'h44);
    idle(3);
    cycle(0, 1, 1, 0, 32'h00000001, 8'h61);
    idle(3);
    cycle(0, 1, 1, 0, 32'h00000005, 8'h21);
    idle(3);
`endif

    // Randomized traffic: key/mode churn every cycle, sporadic resets and gaps.
    for (int i = 0; i < 3000; i++) begin
      logic [D_WIDTH-1:0] d;
      if ($urandom_range(0, 1) == 0) d = 8'($urandom_range(8'h41, 8'h7A));
      else d = 8'($urandom);
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 4) == 0), 1'($urandom), 32'($urandom), d);
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
